// File: rtl/logic_op_pkg.sv
// ---------------------------------------------------------------------------
// logic_op_pkg
// Shared types and helper functions for the logic_op_pipe datapath primitive.
//   op_e      : runtime-selectable bitwise operation (AND, OR, XOR, NAND)
//   state_e   : accumulate FSM states
//   apply_op  : per-beat result r = a op b
//   fold_op   : combines the running accumulator with a beat result
// The functions work on OP_MAX_W-bit words. Callers zero-extend their
// WIDTH-bit operands and truncate the result, so any WIDTH <= OP_MAX_W is
// supported. Every operation is bitwise, so the padding bits never affect
// the low WIDTH bits.
// ---------------------------------------------------------------------------
package logic_op_pkg;

  localparam int unsigned OP_MAX_W = 64;

  typedef logic [OP_MAX_W-1:0] op_word_t;

  typedef enum logic [1:0] {
    OP_AND  = 2'd0,
    OP_OR   = 2'd1,
    OP_XOR  = 2'd2,
    OP_NAND = 2'd3
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_e;

  function automatic op_word_t apply_op(op_e op, op_word_t a, op_word_t b);
    op_word_t res;
    case (op)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NAND: res = ~(a & b);
      default: res = a & b;
    endcase
    return res;
  endfunction

  // NAND packets fold with AND: the packet result is the AND of the
  // individual NAND beat results, not a chained NAND.
  function automatic op_word_t fold_op(op_e op, op_word_t acc, op_word_t r);
    op_word_t res;
    case (op)
      OP_OR:   res = acc | r;
      OP_XOR:  res = acc ^ r;
      default: res = acc & r;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/logic_op_core.sv
// ---------------------------------------------------------------------------
// logic_op_core
// Purely combinational datapath of logic_op_pipe.
//   op   : operation selector (op_e encoding)
//   a, b : WIDTH-bit operands
//   acc  : current accumulator value
//   r    : beat result a op b
//   fold : acc folded with r according to op
// WIDTH must not exceed logic_op_pkg::OP_MAX_W.
// ---------------------------------------------------------------------------
module logic_op_core
  import logic_op_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] fold
);

  assign r    = WIDTH'(apply_op(op_e'(op), OP_MAX_W'(a), OP_MAX_W'(b)));
  assign fold = WIDTH'(fold_op(op_e'(op), OP_MAX_W'(acc), OP_MAX_W'(r)));

endmodule

// File: rtl/logic_op_pipe.sv
// ---------------------------------------------------------------------------
// logic_op_pipe
// Bitwise two-operand logic unit with one registered output stage and a
// valid/ready handshake on both sides. Accumulate packets (in_acc=1) are
// folded into a single result emitted on the beat marked in_last.
//
// Parameters: WIDTH (operand/result width), CNT_W (beat counter width).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake; in_ready = !out_valid | out_ready
//   in_a, in_b          operands
//   in_op               0=AND 1=OR 2=XOR 3=NAND (latched for a whole packet)
//   in_acc, in_last     accumulate-packet marker and final-beat marker
//   out_valid/out_ready output handshake
//   out_data            result
//   out_beats           beats folded into out_data, saturating at 2^CNT_W-1
// Build option LOGIC_OP_PIPE_PARITY_EN adds:
//   out_parity          XOR-reduce of out_data, registered alongside it
//   err                 sticky: a non-accumulate beat arrived mid-packet
// ---------------------------------------------------------------------------
module logic_op_pipe
  import logic_op_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic             in_acc,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_beats
`ifdef LOGIC_OP_PIPE_PARITY_EN
  ,
  output logic             out_parity,
  output logic             err
`endif
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

  logic             accept;
  logic             in_accum;
  op_e              op_sel;
  logic [WIDTH-1:0] beat_r;
  logic [WIDTH-1:0] fold_r;

  logic             load;
  logic [WIDTH-1:0] load_data;
  logic [CNT_W-1:0] load_beats;

  // Shared ready: a stalled output register also stalls accumulation.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign in_accum = (state_q == ST_ACCUM);

  // Inside a packet the op latched on the first beat wins over in_op.
  assign op_sel   = in_accum ? op_q : op_e'(in_op);

  assign cnt_inc  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  logic_op_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op   (op_sel),
    .a    (in_a),
    .b    (in_b),
    .acc  (acc_q),
    .r    (beat_r),
    .fold (fold_r)
  );

  // Next-state and output-load decision. A beat with in_acc=0 while in
  // ACCUM is handled exactly like an accumulate beat.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned; otherwise synthesis infers a latch.
    state_d    = state_q;
    op_d       = op_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    load       = 1'b0;
    load_data  = beat_r;
    load_beats = CNT_W'(1);

    if (accept) begin
      if (!in_accum) begin
        if (in_acc && !in_last) begin
          state_d = ST_ACCUM;
          op_d    = op_e'(in_op);
          acc_d   = beat_r;
          cnt_d   = CNT_W'(1);
        end else begin
          load = 1'b1;
        end
      end else if (in_last) begin
        load       = 1'b1;
        load_data  = fold_r;
        load_beats = cnt_inc;
        state_d    = ST_IDLE;
        acc_d      = '0;
        cnt_d      = '0;
      end else begin
        acc_d = fold_r;
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_AND;
      acc_q     <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_beats <= '0;
`ifdef LOGIC_OP_PIPE_PARITY_EN
      out_parity <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= load_data;
        out_beats <= load_beats;
`ifdef LOGIC_OP_PIPE_PARITY_EN
        out_parity <= ^load_data;
`endif
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef LOGIC_OP_PIPE_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (accept && in_accum && !in_acc) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_logic_op_pipe.sv
// ---------------------------------------------------------------------------
// tb_logic_op_pipe
// Directed bench for logic_op_pipe. Two instances share all inputs: dut
// (WIDTH=8, CNT_W=8) and dut_sat (WIDTH=8, CNT_W=2) for counter saturation.
// Inputs change and outputs are sampled 1 time unit after a rising edge.
// ---------------------------------------------------------------------------
module tb_logic_op_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [1:0] in_op;
  logic       in_acc;
  logic       in_last;
  logic       out_ready;

  logic       in_ready, in_ready_s;
  logic       out_valid, out_valid_s;
  logic [7:0] out_data, out_data_s;
  logic [7:0] out_beats;
  logic [1:0] out_beats_s;
`ifdef LOGIC_OP_PIPE_PARITY_EN
  logic       out_parity, out_parity_s;
  logic       err, err_s;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  localparam logic [1:0] AND_OP  = 2'd0;
  localparam logic [1:0] OR_OP   = 2'd1;
  localparam logic [1:0] XOR_OP  = 2'd2;
  localparam logic [1:0] NAND_OP = 2'd3;

  logic_op_pipe #(.WIDTH(8), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_acc    (in_acc),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_beats (out_beats)
`ifdef LOGIC_OP_PIPE_PARITY_EN
    ,
    .out_parity(out_parity),
    .err       (err)
`endif
  );

  logic_op_pipe #(.WIDTH(8), .CNT_W(2)) dut_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_s),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_acc    (in_acc),
    .in_last   (in_last),
    .out_valid (out_valid_s),
    .out_ready (out_ready),
    .out_data  (out_data_s),
    .out_beats (out_beats_s)
`ifdef LOGIC_OP_PIPE_PARITY_EN
    ,
    .out_parity(out_parity_s),
    .err       (err_s)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    total_cnt++;
    assert (observed === expected) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Present one beat for exactly one rising edge, then drop in_valid.
  task automatic beat(input logic [7:0] a, input logic [7:0] b,
                      input logic [1:0] op, input logic acc, input logic last);
    in_a     = a;
    in_b     = b;
    in_op    = op;
    in_acc   = acc;
    in_last  = last;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_op     = '0;
    in_acc    = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    // Reset state
    #11;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_beats", 32'(out_beats), 32'd0);
    #1 rst_n = 1'b1;
    #1;
    check("rst_in_ready",  32'(in_ready),  32'd1);
`ifdef LOGIC_OP_PIPE_PARITY_EN
    check("rst_err",       32'(err),        32'd0);
    check("rst_parity",    32'(out_parity), 32'd0);
`endif
    idle_cycle();

    // Single beats, a=F0 b=3C, one per op
    beat(8'hF0, 8'h3C, AND_OP, 1'b0, 1'b0);
    check("and_valid", 32'(out_valid), 32'd1);
    check("and_data",  32'(out_data),  32'h30);
    check("and_beats", 32'(out_beats), 32'd1);
    beat(8'hF0, 8'h3C, OR_OP, 1'b0, 1'b0);
    check("or_data",   32'(out_data),  32'hFC);
    check("or_beats",  32'(out_beats), 32'd1);
    beat(8'hF0, 8'h3C, XOR_OP, 1'b0, 1'b0);
    check("xor_data",  32'(out_data),  32'hCC);
    beat(8'hF0, 8'h3C, NAND_OP, 1'b0, 1'b0);
    check("nand_data", 32'(out_data),  32'hCF);
    check("nand_valid", 32'(out_valid), 32'd1);
`ifdef LOGIC_OP_PIPE_PARITY_EN
    check("nand_parity", 32'(out_parity), 32'd0);
`endif
    idle_cycle();
    check("drain_valid", 32'(out_valid), 32'd0);

    // Backpressure
    out_ready = 1'b0;
    beat(8'hFF, 8'h0F, AND_OP, 1'b0, 1'b0);
    check("bp_valid",    32'(out_valid), 32'd1);
    check("bp_data",     32'(out_data),  32'h0F);
    check("bp_in_ready", 32'(in_ready),  32'd0);
    idle_cycle();
    idle_cycle();
    check("bp_hold_valid", 32'(out_valid), 32'd1);
    check("bp_hold_data",  32'(out_data),  32'h0F);
    check("bp_hold_beats", 32'(out_beats), 32'd1);
    // Release and present the next beat in the same cycle as the drain
    out_ready = 1'b1;
    in_a      = 8'hAA;
    in_b      = 8'h55;
    in_op     = OR_OP;
    in_acc    = 1'b0;
    in_last   = 1'b0;
    in_valid  = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_next_valid", 32'(out_valid), 32'd1);
    check("bp_next_data",  32'(out_data),  32'hFF);
    idle_cycle();

    // Accumulate XOR packet, in_op changes mid-packet
    beat(8'h01, 8'h00, XOR_OP, 1'b1, 1'b0);
    check("xacc_mid_valid", 32'(out_valid), 32'd0);
    beat(8'h02, 8'h00, AND_OP, 1'b1, 1'b0);
    check("xacc_mid2_valid", 32'(out_valid), 32'd0);
    beat(8'h04, 8'h00, NAND_OP, 1'b1, 1'b1);
    check("xacc_valid", 32'(out_valid), 32'd1);
    check("xacc_data",  32'(out_data),  32'h07);
    check("xacc_beats", 32'(out_beats), 32'd3);
    check("xacc_sat_beats", 32'(out_beats_s), 32'd3);
`ifdef LOGIC_OP_PIPE_PARITY_EN
    check("xacc_parity", 32'(out_parity), 32'd1);
`endif
    idle_cycle();

    // Accumulate NAND packet: beat results 0F, F0, AND-folded to 00
    beat(8'hF0, 8'hF0, NAND_OP, 1'b1, 1'b0);
    beat(8'h0F, 8'hFF, OR_OP, 1'b1, 1'b1);
    check("nacc_valid", 32'(out_valid), 32'd1);
    check("nacc_data",  32'(out_data),  32'h00);
    check("nacc_beats", 32'(out_beats), 32'd2);
    idle_cycle();

    // Single-beat accumulate packet (in_acc=1, in_last=1 from IDLE)
    beat(8'h5A, 8'h0F, XOR_OP, 1'b1, 1'b1);
    check("single_acc_data",  32'(out_data),  32'h55);
    check("single_acc_beats", 32'(out_beats), 32'd1);
    idle_cycle();

    // Counter saturation: 5-beat OR packet
    beat(8'h01, 8'h00, OR_OP, 1'b1, 1'b0);
    beat(8'h02, 8'h00, OR_OP, 1'b1, 1'b0);
    beat(8'h04, 8'h00, OR_OP, 1'b1, 1'b0);
    beat(8'h08, 8'h00, OR_OP, 1'b1, 1'b0);
    beat(8'h10, 8'h00, OR_OP, 1'b1, 1'b1);
    check("sat_data",       32'(out_data_s),  32'h1F);
    check("sat_beats_cnt2", 32'(out_beats_s), 32'd3);
    check("sat_beats_cnt8", 32'(out_beats),   32'd5);
    idle_cycle();

    // Non-accumulate beat inside a packet is folded like an accumulate beat
    beat(8'h01, 8'h00, XOR_OP, 1'b1, 1'b0);
    beat(8'h02, 8'h00, AND_OP, 1'b0, 1'b0);
    check("proto_no_output", 32'(out_valid), 32'd0);
`ifdef LOGIC_OP_PIPE_PARITY_EN
    check("proto_err", 32'(err), 32'd1);
`endif
    beat(8'h04, 8'h00, AND_OP, 1'b1, 1'b1);
    check("proto_data",  32'(out_data),  32'h07);
    check("proto_beats", 32'(out_beats), 32'd3);
`ifdef LOGIC_OP_PIPE_PARITY_EN
    check("proto_parity",     32'(out_parity), 32'd1);
    check("proto_err_sticky", 32'(err),        32'd1);
`endif
    idle_cycle();

    // Reset mid-packet, away from any clock edge
    beat(8'hFF, 8'hFF, AND_OP, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_valid", 32'(out_valid), 32'd0);
    check("rstmid_data",  32'(out_data),  32'd0);
    check("rstmid_beats", 32'(out_beats), 32'd0);
`ifdef LOGIC_OP_PIPE_PARITY_EN
    check("rstmid_err",   32'(err),       32'd0);
`endif
    #2 rst_n = 1'b1;
    beat(8'h0F, 8'hF0, XOR_OP, 1'b0, 1'b0);
    check("post_rst_valid", 32'(out_valid), 32'd1);
    check("post_rst_data",  32'(out_data),  32'hFF);
    check("post_rst_beats", 32'(out_beats), 32'd1);
    idle_cycle();

    // Reset with a pending (backpressured) output
    out_ready = 1'b0;
    beat(8'h33, 8'h0F, AND_OP, 1'b0, 1'b0);
    check("pend_valid", 32'(out_valid), 32'd1);
    check("pend_data",  32'(out_data),  32'h03);
    #2 rst_n = 1'b0;
    #1;
    check("rstpend_valid", 32'(out_valid), 32'd0);
    check("rstpend_ready", 32'(in_ready),  32'd1);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    beat(8'h3C, 8'h0F, NAND_OP, 1'b0, 1'b0);
    check("post_rst2_data",  32'(out_data),  32'hF3);
    check("post_rst2_beats", 32'(out_beats), 32'd1);
    idle_cycle();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
